// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory-access stage.
package lc3_mem_pkg;

  localparam int unsigned CntW          = 4;
  localparam logic [15:0] IoAddrDefault = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StRdAct,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StIoRd,
    StIoWr,
    StRelease
  } mem_state_t;

endpackage

// File: rtl/lc3_mem_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync2 #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access stage: sequences async SRAM pins and the switch/hex I/O word
// from the control FSM's level-held Mem_OE/Mem_WE strobes.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 2,
  parameter logic [15:0] IO_ADDR   = IoAddrDefault
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        mem_oe,
  input  logic        mem_we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  input  logic [15:0] sw,
  output logic [15:0] hex_data
);

  localparam logic [CntW-1:0] RdLoad = CntW'(RD_CYCLES - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WR_CYCLES - 1);

  mem_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     wdata_q;
  logic [15:0]     sw_sync;
  logic            io_hit;

  logic ce_d, oe_d, we_d, bytes_d, dq_oe_d;
  logic ce_q, oe_q, we_q, bytes_q, dq_oe_q;
  logic [19:0] sram_addr_q;
  logic [15:0] sram_dq_out_q, rdata_q, hex_q;
  logic        rdata_valid_q;

  sync2 #(
    .Width(16)
  ) u_sw_sync (
    .clk_i (Clk),
    .rst_ni(Reset),
    .d_i   (sw),
    .q_o   (sw_sync)
  );

  assign io_hit = (addr == IO_ADDR);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write wins over read when both strobes are seen in the same idle cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (mem_we) begin
          state_d = io_hit ? StIoWr : StWrSetup;
        end else if (mem_oe) begin
          if (io_hit) begin
            state_d = StIoRd;
          end else begin
            state_d = StRdAct;
            cnt_d   = RdLoad;
          end
        end
      end
      StRdAct: begin
        if (cnt_q == '0) state_d = StRelease;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = WrLoad;
      end
      StWrPulse: begin
        if (cnt_q == '0) state_d = StWrHold;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StWrHold:        state_d = StRelease;
      StIoRd, StIoWr:  state_d = StRelease;
      // Hold here until the FSM drops its strobe so a level-held request cannot retrigger.
      StRelease: begin
        if (!mem_oe && !mem_we) state_d = StIdle;
      end
      default:         state_d = StIdle;
    endcase
  end

  // Pin levels are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    bytes_d = 1'b1;
    dq_oe_d = 1'b0;
    case (state_d)
      StRdAct: begin
        ce_d    = 1'b0;
        oe_d    = 1'b0;
        bytes_d = 1'b0;
      end
      StWrSetup, StWrHold: begin
        ce_d    = 1'b0;
        bytes_d = 1'b0;
        dq_oe_d = 1'b1;
      end
      StWrPulse: begin
        ce_d    = 1'b0;
        bytes_d = 1'b0;
        dq_oe_d = 1'b1;
        we_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ce_q          <= 1'b1;
      oe_q          <= 1'b1;
      we_q          <= 1'b1;
      bytes_q       <= 1'b1;
      dq_oe_q       <= 1'b0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      hex_q         <= '0;
    end else begin
      ce_q          <= ce_d;
      oe_q          <= oe_d;
      we_q          <= we_d;
      bytes_q       <= bytes_d;
      dq_oe_q       <= dq_oe_d;
      rdata_valid_q <= 1'b0;
      if (state_q == StIdle && (mem_we || mem_oe) && !io_hit) begin
        sram_addr_q <= {4'b0000, addr};
      end
      if (state_q == StIdle && mem_we) begin
        wdata_q <= wdata;
        if (!io_hit) sram_dq_out_q <= wdata;
      end
      if (state_q == StRdAct && cnt_q == '0) begin
        rdata_q       <= sram_dq_in;
        rdata_valid_q <= 1'b1;
      end
      if (state_q == StIoRd) begin
        rdata_q       <= sw_sync;
        rdata_valid_q <= 1'b1;
      end
      if (state_q == StIoWr) hex_q <= wdata_q;
    end
  end

  assign busy        = (state_q != StIdle);
  assign sram_ce_n   = ce_q;
  assign sram_oe_n   = oe_q;
  assign sram_we_n   = we_q;
  assign sram_ub_n   = bytes_q;
  assign sram_lb_n   = bytes_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign hex_data    = hex_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: per-cycle pin vectors plus a read-data scoreboard.
module tb_lc3_mem_ctrl;

  typedef logic [6:0] pv_t;  // {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, busy}
  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  localparam pv_t PI = 7'b1111100;  // idle
  localparam pv_t PR = 7'b0010001;  // read active
  localparam pv_t PB = 7'b1111101;  // busy, no strobes (release / io)
  localparam pv_t PS = 7'b0110011;  // write setup / hold
  localparam pv_t PW = 7'b0100011;  // write pulse

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        mem_oe = 1'b0, mem_we = 1'b0;
  logic [15:0] addr = '0, wdata = '0, sram_dq_in = '0, sw = '0;
  logic [15:0] rdata, sram_dq_out, hex_data;
  logic [19:0] sram_addr;
  logic        rdata_valid, busy, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic        sram_dq_oe;

  int   cyc = 0;
  int   n_chk = 0, n_err = 0;  // main-flow comparisons
  int   m_chk = 0, m_err = 0;  // scoreboard comparisons
  exp_t sb[$];

  lc3_mem_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .busy       (busy),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sw         (sw),
    .hex_data   (hex_data)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest expected read, in data and cycle.
  always @(negedge Clk) begin
    if (Reset && rdata_valid) begin
      m_chk++;
      if (sb.size() == 0) begin
        m_err++;
        $display("FAIL unexpected_valid: rdata %h at cycle %0d, none expected", rdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rdata !== e.data || cyc != e.cyc) begin
          m_err++;
          $display("FAIL rdata: got %h at cycle %0d, expected %h at cycle %0d",
                   rdata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  function automatic pv_t pins();
    return {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input int lat);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + lat;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; drives the request and checks pins each following cycle.
  task automatic run_txn(input string name, input logic we, input logic oe,
                         input logic [15:0] a, input logic [15:0] wd,
                         input int hold, input int n, input pv_t exp[8]);
    mem_we = we;
    mem_oe = oe;
    addr   = a;
    wdata  = wd;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      chk($sformatf("%s_pins_c%0d", name, i), 32'(pins()), 32'(exp[i]));
      @(posedge Clk);
      #1;
      if (i == hold - 1) begin
        mem_we = 1'b0;
        mem_oe = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pv_t v[8];
    sw = 16'h00A5;
    #12;
    chk("reset_pins", 32'(pins()), 32'(PI));
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_valid", 32'(rdata_valid), 32'h0);
    chk("reset_hex", 32'(hex_data), 32'h0);
    chk("reset_addr", 32'(sram_addr), 32'h0);
    chk("reset_dqout", 32'(sram_dq_out), 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // SRAM read, strobe held past completion: stays in release until it falls.
    sram_dq_in = 16'h1234;
    push(16'h1234, 3);
    v = '{PI, PR, PR, PB, PB, PB, PI, PI};
    run_txn("rd", 1'b0, 1'b1, 16'h3000, 16'h0, 5, 8, v);
    chk("rd_addr", 32'(sram_addr), 32'h03000);

    // SRAM write.
    v = '{PI, PS, PW, PW, PS, PB, PI, PI};
    run_txn("wr", 1'b1, 1'b0, 16'h0005, 16'hBEEF, 3, 8, v);
    chk("wr_addr", 32'(sram_addr), 32'h00005);
    chk("wr_dqout", 32'(sram_dq_out), 32'hBEEF);
    chk("rdata_hold", 32'(rdata), 32'h1234);

    // I/O read of switches, then hex write; SRAM pins stay quiet.
    push(16'h00A5, 2);
    v = '{PI, PB, PB, PI, PI, PI, PI, PI};
    run_txn("iord", 1'b0, 1'b1, 16'hFFFF, 16'h0, 2, 5, v);
    chk("iord_addr", 32'(sram_addr), 32'h00005);
    run_txn("iowr", 1'b1, 1'b0, 16'hFFFF, 16'h0042, 2, 5, v);
    chk("iowr_hex", 32'(hex_data), 32'h0042);
    chk("iowr_dqout", 32'(sram_dq_out), 32'hBEEF);

    // Both strobes: write wins, no read data.
    v = '{PI, PS, PW, PW, PS, PB, PI, PI};
    run_txn("both", 1'b1, 1'b1, 16'h0010, 16'h1111, 3, 8, v);
    chk("both_addr", 32'(sram_addr), 32'h00010);
    chk("both_dqout", 32'(sram_dq_out), 32'h1111);

    // Back-to-back reads, one idle strobe cycle between them.
    v = '{PI, PR, PR, PB, PI, PI, PI, PI};
    sram_dq_in = 16'hA1A1;
    push(16'hA1A1, 3);
    run_txn("b2b1", 1'b0, 1'b1, 16'h0100, 16'h0, 3, 4, v);
    sram_dq_in = 16'h5C5C;
    push(16'h5C5C, 3);
    run_txn("b2b2", 1'b0, 1'b1, 16'h0101, 16'h0, 3, 6, v);

    // Reset during the write pulse must drop pins without a clock edge.
    mem_we = 1'b1;
    addr   = 16'h0020;
    wdata  = 16'hAAAA;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    #1;
    chk("rstmid_pulse", 32'(pins()), 32'(PW));
    Reset = 1'b0;
    #1;
    chk("rstmid_pins", 32'(pins()), 32'(PI));
    mem_we = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    sram_dq_in = 16'hCAFE;
    push(16'hCAFE, 3);
    v = '{PI, PR, PR, PB, PI, PI, PI, PI};
    run_txn("postrst", 1'b0, 1'b1, 16'h0040, 16'h0, 3, 6, v);

    repeat (4) @(posedge Clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk + m_chk, n_err + m_err);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory-access stage directly downstream of the LC-3 control FSM.
- Consumes the FSM's level-held Mem_OE/Mem_WE strobes, the MAR address and the MDR write data.
- Sequences the async 16-bit SRAM pins with fixed, parameterised timing.
- Decodes the memory-mapped I/O word: switch read, hex-display register write.
- Returns read data to the MDR input mux with a one-cycle valid pulse.

Parameters:
RD_CYCLES, 2, cycles CE_N/OE_N held low before read data is captured (legal range 1..15)
WR_CYCLES, 2, cycles WE_N held low per write (legal range 1..15)
IO_ADDR, 16'hFFFF, address decoded as I/O instead of SRAM

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
mem_oe  input  1  read request strobe from control FSM, active-high, level-held
mem_we  input  1  write request strobe from control FSM, active-high, level-held
addr  input  16  MAR value
wdata  input  16  MDR value to write
rdata  output  16  captured read data to MDR mux
rdata_valid  output  1  one-cycle pulse when rdata is updated
busy  output  1  high while a transaction is in flight
sram_ce_n  output  1  SRAM chip enable, active-low
sram_oe_n  output  1  SRAM output enable, active-low
sram_we_n  output  1  SRAM write enable, active-low
sram_ub_n  output  1  upper byte enable, active-low
sram_lb_n  output  1  lower byte enable, active-low
sram_addr  output  20  SRAM address, {4'b0, addr}
sram_dq_out  output  16  data driven to SRAM
sram_dq_oe  output  1  tri-state enable for sram_dq_out, top level owns the pad
sram_dq_in  input  16  data from SRAM pads
sw  input  16  board switches, asynchronous
hex_data  output  16  hex-display register

Behaviour:
- Reset (async, Reset=0) state:
  - State = IDLE.
  - sram_ce_n = sram_oe_n = sram_we_n = sram_ub_n = sram_lb_n = 1.
  - sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0.
  - rdata = 0; rdata_valid = 0; busy = 0; hex_data = 0.
  - sw synchroniser flops = 0.
- All outputs are registered, except busy, which is decoded from state.
- Request sampling: in IDLE only. If mem_we=1 a write starts, with priority over mem_oe. Else if mem_oe=1 a read starts.
- addr and wdata are latched on the request cycle and held for the whole transaction.
- SRAM read: IDLE -> RD_ACT.
  - RD_ACT: ce_n = oe_n = ub_n = lb_n = 0 for RD_CYCLES cycles.
  - On the last RD_ACT cycle, sram_dq_in is registered into rdata and rdata_valid pulses the following cycle.
  - Next state: RELEASE.
  - Latency from request sample to rdata_valid = RD_CYCLES+1 cycles.
- SRAM write: IDLE -> WR_SETUP (1 cycle) -> WR_PULSE (WR_CYCLES cycles) -> WR_HOLD (1 cycle) -> RELEASE.
  - WR_SETUP: ce_n/ub_n/lb_n = 0, we_n = 1, dq_oe = 1.
  - WR_PULSE: we_n = 0.
  - WR_HOLD: we_n = 1; ce_n and dq_oe remain asserted.
  - oe_n stays 1 throughout a write.
- I/O access (latched addr == IO_ADDR): no SRAM pin toggles.
  - Read: IDLE -> IO_RD (1 cycle). rdata = synchronised sw, rdata_valid pulses next cycle, then RELEASE.
  - Write: IDLE -> IO_WR (1 cycle). hex_data = wdata, then RELEASE.
- RELEASE: all SRAM strobes inactive, dq_oe = 0. Stay until mem_oe=0 and mem_we=0, then IDLE. This prevents a held FSM strobe from retriggering.
- busy = 1 in every state except IDLE.
- Strobe dropped mid-transaction: the transaction completes normally. RELEASE exits immediately.
- Strobe changes mid-transaction (e.g. oe->we): ignored until IDLE.
- Reset asserted mid-write: pins go inactive asynchronously. we_n rises before or together with dq_oe falling, which is acceptable because both occur in the same event.
- sw passes through a 2-flop synchroniser before use.
- rdata holds its value between reads.

Decomposition:
- Shared package lc3_mem_pkg:
  - mem_state_t enum: IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD, IO_RD, IO_WR, RELEASE.
  - IO_ADDR default constant.
  - 4-bit wait-counter width constant.
- Sub-module sync2: 2-flop synchroniser, parameterised width, async active-low reset. Instantiated for sw.

Test Plan:
- SRAM read, RD_CYCLES=2: addr=16'h3000 with sram_dq_in=16'h1234, mem_oe held 3 cycles -> ce_n/oe_n low exactly 2 cycles; rdata=16'h1234 with rdata_valid high 1 cycle at request+3; controller returns to IDLE only after mem_oe falls.
- SRAM write, WR_CYCLES=2: addr=16'h0005, wdata=16'hBEEF, mem_we held 3 cycles -> sram_addr=20'h00005; dq_oe high 4 cycles with dq_out=16'hBEEF; we_n low exactly cycles 2-3; oe_n never low.
- I/O: sw=16'h00A5 stable 3 cycles, then read of 16'hFFFF -> rdata=16'h00A5 and no SRAM strobe activity. Write of 16'hFFFF with wdata=16'h0042 -> hex_data=16'h0042.
- Simultaneous mem_oe=mem_we=1 in IDLE -> write sequence runs; rdata_valid never pulses.
- Reset driven low during WR_PULSE -> all SRAM strobes 1, dq_oe=0, busy=0 without waiting for a clock edge; after release, the next mem_oe completes a normal read.
- Back-to-back reads with 1 idle cycle between strobes -> two rdata_valid pulses, each with the correct data.
